// File: rtl/muldiv_pkg.sv
// Shared encodings and funct3 decode helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  function automatic logic is_rem(input logic [2:0] f3);
    return f3[2] & f3[1];
  endfunction

  function automatic logic is_high(input logic [2:0] f3);
    return !f3[2] && (f3[1:0] != 2'b00);
  endfunction

  // MUL is treated as signed; its low half is identical either way.
  function automatic logic a_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic b_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_operand_cond.sv
// Operand conditioning: magnitudes, result sign and the divide special cases.
module muldiv_operand_cond import muldiv_pkg::*; #(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] abs_a,
  output logic [XLEN-1:0] abs_b,
  output logic            neg_result,
  output logic            div_by_zero,
  output logic            div_overflow
);

  logic sign_a;
  logic sign_b;

  always_comb begin
    sign_a = a_signed(funct3) & op_a[XLEN-1];
    sign_b = b_signed(funct3) & op_b[XLEN-1];
    abs_a  = sign_a ? -op_a : op_a;
    abs_b  = sign_b ? -op_b : op_b;
    // A remainder follows the dividend's sign; products and quotients the sign xor.
    neg_result   = is_rem(funct3) ? sign_a : (sign_a ^ sign_b);
    div_by_zero  = is_div(funct3) && (op_b == '0);
    div_overflow = is_div(funct3) && !funct3[0] &&
                   (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (&op_b);
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M execution unit: 32-cycle shift-add multiply and restoring divide.
module muldiv_unit import muldiv_pkg::*; #(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        f3_r;
  logic [4:0]        rd_r;
  logic              neg_r;
  logic [XLEN-1:0]   opnd_r;
  logic [2*XLEN-1:0] acc;

  logic [XLEN-1:0]   abs_a, abs_b;
  logic              neg_result, div_by_zero, div_overflow;

  muldiv_operand_cond #(.XLEN(XLEN)) u_cond (
    .funct3       (funct3),
    .op_a         (op_a),
    .op_b         (op_b),
    .abs_a        (abs_a),
    .abs_b        (abs_b),
    .neg_result   (neg_result),
    .div_by_zero  (div_by_zero),
    .div_overflow (div_overflow)
  );

  logic [XLEN:0]     mul_sum, rem_sh, diff;
  logic [2*XLEN-1:0] acc_nx, prod;
  logic [XLEN-1:0]   quo, rem, final_val, special_val;

  // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide.
  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd_r} : '0);
    rem_sh  = acc[2*XLEN-1:XLEN-1];
    diff    = rem_sh - {1'b0, opnd_r};
    if (is_div(f3_r)) begin
      acc_nx = diff[XLEN] ? {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                          : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      acc_nx = {mul_sum, acc[XLEN-1:1]};
    end
    prod = neg_r ? -acc_nx : acc_nx;
    quo  = acc_nx[XLEN-1:0];
    rem  = acc_nx[2*XLEN-1:XLEN];
    if (is_div(f3_r)) begin
      final_val = is_rem(f3_r) ? (neg_r ? -rem : rem) : (neg_r ? -quo : quo);
    end else begin
      final_val = is_high(f3_r) ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    end
    if (div_by_zero) begin
      special_val = is_rem(funct3) ? op_a : '1;
    end else begin
      special_val = is_rem(funct3) ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      f3_r   <= '0;
      rd_r   <= '0;
      neg_r  <= 1'b0;
      opnd_r <= '0;
      acc    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      rd_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_CALC: begin
          if (kill) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            acc <= acc_nx;
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_LAST) begin
              result <= final_val;
              rd_out <= rd_r;
              done   <= 1'b1;
              busy   <= 1'b0;
              state  <= S_DONE;
            end
          end
        end
        default: begin
          // IDLE and DONE both accept; kill alongside start drops the request.
          if (start && !kill) begin
            f3_r  <= funct3;
            rd_r  <= rd_in;
            neg_r <= neg_result;
            if (div_by_zero || div_overflow) begin
              result <= special_val;
              rd_out <= rd_in;
              done   <= 1'b1;
              busy   <= 1'b0;
              state  <= S_DONE;
            end else begin
              opnd_r <= is_div(funct3) ? abs_b : abs_a;
              acc    <= {{XLEN{1'b0}}, (is_div(funct3) ? abs_a : abs_b)};
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= S_CALC;
            end
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
